input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Front-end stage between the board pins (KEY, SW) and the processor core.
- Synchronises and debounces the two push-buttons and four slide switches, and produces clean levels plus single-cycle edge pulses.
- Generates the stretched, glitch-free active-low reset that drives the core's rst_n, replacing the bare shift-register synchroniser at top level.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles an input must stay stable before its level is accepted (10 ms at 50 MHz); legal minimum 2.
- RST_HOLD_CYCLES, 1024, cycles core_rst_n is held low after all reset causes clear; legal minimum 1.
- DB_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.
- RH_W, $clog2(RST_HOLD_CYCLES+1), reset-hold counter width.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- key_in  input  2  raw push-buttons, active-low (pressed = 0), asynchronous to clk.
- sw_in  input  4  raw slide switches, asynchronous to clk.
- key_level  output  2  debounced key state, active-low.
- key_press  output  2  one-cycle pulse when key_level[i] goes 1->0.
- key_release  output  2  one-cycle pulse when key_level[i] goes 0->1.
- sw_level  output  4  debounced switch state.
- sw_changed  output  4  one-cycle pulse when sw_level[i] changes, in either direction.
- core_rst_n  output  1  registered active-low reset to the core.

Behaviour:
- Reset values (rst_n=0, asynchronous): key sync flops=1, key_level=2'b11, sw sync flops=0, sw_level=0, all pulses=0, all debounce counters=0, hold counter=0, core_rst_n=0.
- Per channel (6 independent channels): two-flop synchroniser s0->s1.
- Debounce rule, each cycle:
  - If s1==level: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: level<=s1, counter<=0.
  - Else: counter<=counter+1.
  - Any bounce back to the current level restarts the count.
- Latency: input changes before edge 1 and then stays stable. s1 updates at edge 2. level and its pulse update at edge DEBOUNCE_CYCLES+2.
- Pulses:
  - Registered; asserted for exactly the one cycle in which the corresponding level changes.
  - key_press and key_release are never both high on the same bit.
  - Channels are independent; simultaneous events on different bits are all reported in the same cycle.
- Reset stretcher:
  - Cause active = (key_level[0]==0).
  - While a cause is active: hold<=0, core_rst_n<=0.
  - Otherwise, while hold<RST_HOLD_CYCLES: hold<=hold+1.
  - core_rst_n<=1 when the next value of hold equals RST_HOLD_CYCLES, i.e. on the RST_HOLD_CYCLES-th edge with no cause active.
  - hold saturates at RST_HOLD_CYCLES; no wrap.
  - Key[0] pressed again mid-count: count restarts from 0 and core_rst_n stays 0.
  - Key[0] pressed after release: core_rst_n falls in the same cycle key_level[0] falls.
- rst_n asserted mid-operation: all state returns to reset values immediately, without a clock edge. Debounce progress is discarded.
- key_level[1], key_press[1] and the switch outputs never influence core_rst_n.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=16):
- Power-on: release rst_n with key_in=2'b11 -> core_rst_n=0 for 15 edges, rises to 1 on edge 16; key_level=2'b11, sw_level=0, no pulses.
- Clean press: key_in[1] 1->0 before edge 1, held low -> key_level[1]=0 and key_press[1]=1 at edge 10 only; release it later -> key_release[1] pulse exactly 10 edges after the change.
- Bounce: sw_in[2] toggles every 3 cycles for 21 cycles, then held at 1 -> sw_level[2] rises, with one sw_changed[2] pulse, 10 edges after the last toggle; no earlier pulse.
- Glitch: key_in[0] low for 5 cycles then high -> key_level, pulses and core_rst_n unchanged.
- Key reset: with core_rst_n=1, hold key_in[0] low -> core_rst_n falls with key_level[0] at edge 10. Release -> core_rst_n rises 16 edges after key_level[0] returns to 1. A re-press at hold count 7 restarts the full count.
- Async reset: assert rst_n mid debounce and mid hold-count, between clock edges -> core_rst_n=0 and all outputs at reset values before the next edge; after deassertion, a full DEBOUNCE_CYCLES+2 is needed for any level change.

Source files
------------

// File: rtl/input_conditioner_if.sv
// input_conditioner_if
//   Board-facing bundle of the input conditioner: raw pins in, clean levels,
//   edge pulses and the stretched core reset out.
//   master : board/bench side, drives the raw pins and observes the outputs.
//   slave  : conditioner side, samples the raw pins and drives the outputs.
//   key_in[1:0]      raw push-buttons, active-low, asynchronous
//   sw_in[3:0]       raw slide switches, asynchronous
//   key_level[1:0]   debounced key state, active-low
//   key_press[1:0]   one-cycle pulse on key_level 1->0
//   key_release[1:0] one-cycle pulse on key_level 0->1
//   sw_level[3:0]    debounced switch state
//   sw_changed[3:0]  one-cycle pulse on any sw_level change
//   core_rst_n       registered, stretched active-low core reset
interface input_conditioner_if;
    logic [1:0] key_in;
    logic [3:0] sw_in;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [3:0] sw_level;
    logic [3:0] sw_changed;
    logic       core_rst_n;

    modport master (
        output key_in, sw_in,
        input  key_level, key_press, key_release, sw_level, sw_changed, core_rst_n
    );

    modport slave (
        input  key_in, sw_in,
        output key_level, key_press, key_release, sw_level, sw_changed, core_rst_n
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner
//   Synchronises and debounces two push-buttons and four slide switches,
//   produces clean levels plus single-cycle edge pulses, and generates the
//   stretched active-low reset for the core (key[0] acts as reset button).
//   clk    : system clock (CLOCK_50 domain)
//   rst_n  : asynchronous active-low reset
//   io     : input_conditioner_if.slave (raw pins in, conditioned outputs)
// All outputs come from flops or from AND-ing flops; no input reaches an
// output combinationally.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_HOLD_CYCLES = 1024,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES),
    parameter int RH_W            = $clog2(RST_HOLD_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  io
);

    localparam int NCH = 6;
    // Channel order {sw[3:0], key[1:0]}; keys idle high, switches idle low.
    localparam logic [NCH-1:0] RST_VAL = 6'b000011;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RH_W-1:0] RH_END  = RH_W'(RST_HOLD_CYCLES);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] s0_q, s0_d;
    logic [NCH-1:0] s1_q, s1_d;
    logic [NCH-1:0] level_q, level_d;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [DB_W-1:0] cnt_q [NCH];
    logic [DB_W-1:0] cnt_d [NCH];
    logic [RH_W-1:0] hold_q, hold_d;
    logic            core_rst_n_q, core_rst_n_d;
    logic            cause_active;
    logic            cause_starting;

    assign raw = {io.sw_in, io.key_in};

    always_comb begin
        s0_d = raw;
        s1_d = s0_q;
    end

    // A channel's level only moves after s1 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement clears the count.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s1_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = s1_q[i];
                    pulse_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The hold counter follows the registered key[0] level, so release is
    // stretched by a full RST_HOLD_CYCLES edges. The falling edge of the
    // level is also looked at directly so core_rst_n drops in the same cycle
    // key_level[0] does rather than one cycle later.
    always_comb begin
        cause_active   = ~level_q[0];
        cause_starting = ~level_d[0];
        hold_d         = hold_q;
        if (cause_active) begin
            hold_d = '0;
        end else if (hold_q < RH_END) begin
            hold_d = hold_q + 1'b1;
        end
        core_rst_n_d = ~cause_active & ~cause_starting & (hold_d == RH_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q         <= RST_VAL;
            s1_q         <= RST_VAL;
            level_q      <= RST_VAL;
            pulse_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            hold_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            level_q      <= level_d;
            pulse_q      <= pulse_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            hold_q       <= hold_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // The pulse flop marks the cycle the level changed; the new level tells
    // which direction, so press and release can never coincide on one bit.
    assign io.key_level   = level_q[1:0];
    assign io.key_press   = pulse_q[1:0] & ~level_q[1:0];
    assign io.key_release = pulse_q[1:0] &  level_q[1:0];
    assign io.sw_level    = level_q[5:2];
    assign io.sw_changed  = pulse_q[5:2];
    assign io.core_rst_n  = core_rst_n_q;

endmodule
